// File: rtl/reg_writeback_unit_pkg.sv
// Shared constants and the mul/div result payload for the write-back stage.
package reg_writeback_unit_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned REG_COUNT = 32;
    localparam logic [ADDR_W-1:0] X0_ADDR = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_unit_wb_result_fifo.sv
// Circular FIFO holding completed mul/div results until the write port is free.
// No fall-through: an entry pushed into an empty FIFO is poppable next cycle.
module wb_result_fifo
    import reg_writeback_unit_pkg::*;
#(
    parameter int unsigned MD_DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(MD_DEPTH),
    localparam int unsigned CNT_W = $clog2(MD_DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push_i,
    input  wb_entry_t        push_data_i,
    input  logic             pop_i,
    output wb_entry_t        pop_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    wb_entry_t        mem_q [MD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == CNT_W'(MD_DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Guard against overflow/underflow; pointers wrap naturally (power-of-two depth).
    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Write-back arbiter in front of the register file write port, with a pending
// scoreboard for in-flight mul/div results. Define WB_FWD_EN for forwarding outputs.
module reg_writeback_unit
    import reg_writeback_unit_pkg::*;
#(
    parameter int unsigned DATA_W   = reg_writeback_unit_pkg::DATA_W,
    parameter int unsigned ADDR_W   = reg_writeback_unit_pkg::ADDR_W,
    parameter int unsigned MD_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WB_VALID,
    input  logic [ADDR_W-1:0] WB_ADDR,
    input  logic [DATA_W-1:0] WB_DATA,
    input  logic              MD_VALID,
    input  logic [ADDR_W-1:0] MD_ADDR,
    input  logic [DATA_W-1:0] MD_DATA,
    output logic              MD_READY,
    input  logic              ISSUE_MD,
    input  logic [ADDR_W-1:0] ISSUE_ADDR,
    input  logic [ADDR_W-1:0] RS1_ADDR,
    input  logic [ADDR_W-1:0] RS2_ADDR,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic              HAZARD,
    output logic              RF_WRITE,
    output logic [ADDR_W-1:0] RF_ADDR,
    output logic [DATA_W-1:0] RF_DATA
`ifdef WB_FWD_EN
    ,
    output logic              FWD1_HIT,
    output logic [DATA_W-1:0] FWD1_DATA,
    output logic              FWD2_HIT,
    output logic [DATA_W-1:0] FWD2_DATA
`endif
);

    localparam int unsigned NREG  = 2 ** ADDR_W;
    localparam int unsigned CNT_W = $clog2(MD_DEPTH + 1);

    wb_entry_t         md_entry;
    wb_entry_t         md_head;
    logic [CNT_W-1:0]  md_count;
    logic              md_full;
    logic              md_empty;
    logic              md_push;
    logic              md_pop;

    logic              sel_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic              rf_write_q, rf_write_d;
    logic [ADDR_W-1:0] rf_addr_q,  rf_addr_d;
    logic [DATA_W-1:0] rf_data_q,  rf_data_d;
    logic [NREG-1:0]   pending_q,  pending_d;
    logic [NREG-1:0]   hazard_vec;

    assign md_entry.addr = MD_ADDR;
    assign md_entry.data = MD_DATA;

    assign MD_READY = (md_count < CNT_W'(MD_DEPTH)) && !RESET;
    assign md_push  = MD_VALID && MD_READY && !md_full;

    wb_result_fifo #(
        .MD_DEPTH (MD_DEPTH)
    ) u_md_fifo (
        .CLK         (CLK),
        .RESET       (RESET),
        .push_i      (md_push),
        .push_data_i (md_entry),
        .pop_i       (md_pop),
        .pop_data_o  (md_head),
        .count_o     (md_count),
        .full_o      (md_full),
        .empty_o     (md_empty)
    );

    // Pipeline result has priority; a mul/div entry only drains on idle WB cycles.
    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        md_pop    = 1'b0;
        if (WB_VALID) begin
            sel_valid = 1'b1;
            sel_addr  = WB_ADDR;
            sel_data  = WB_DATA;
        end else if (!md_empty) begin
            sel_valid = 1'b1;
            md_pop    = 1'b1;
            sel_addr  = md_head.addr;
            sel_data  = md_head.data;
        end
    end

    // Writes to x0 are dropped here since the register file does not hard-wire it.
    always_comb begin
        rf_write_d = sel_valid && (sel_addr != X0_ADDR);
        rf_addr_d  = rf_addr_q;
        rf_data_d  = rf_data_q;
        if (rf_write_d) begin
            rf_addr_d = sel_addr;
            rf_data_d = sel_data;
        end
    end

    // Clear on pop first so a same-cycle issue to that register keeps it pending.
    always_comb begin
        pending_d = pending_q;
        if (md_pop) begin
            pending_d[md_head.addr] = 1'b0;
        end
        if (ISSUE_MD && (ISSUE_ADDR != X0_ADDR)) begin
            pending_d[ISSUE_ADDR] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rf_write_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
            pending_q  <= '0;
        end else begin
            rf_write_q <= rf_write_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
            pending_q  <= pending_d;
        end
    end

`ifdef WB_FWD_EN
    // A register being drained this cycle is forwarded next cycle, so it need not stall.
    logic [NREG-1:0] clear_vec;
    assign clear_vec  = md_pop ? (NREG'(1) << md_head.addr) : '0;
    assign hazard_vec = pending_q & ~clear_vec;

    assign FWD1_HIT  = rf_write_q && (rf_addr_q == RS1_ADDR) && (RS1_ADDR != X0_ADDR);
    assign FWD1_DATA = rf_data_q;
    assign FWD2_HIT  = rf_write_q && (rf_addr_q == RS2_ADDR) && (RS2_ADDR != X0_ADDR);
    assign FWD2_DATA = rf_data_q;
`else
    assign hazard_vec = pending_q;
`endif

    assign HAZARD = hazard_vec[RS1_ADDR] | hazard_vec[RS2_ADDR] | hazard_vec[RD_ADDR];

    assign RF_WRITE = rf_write_q;
    assign RF_ADDR  = rf_addr_q;
    assign RF_DATA  = rf_data_q;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Randomized bench for reg_writeback_unit against a queue-based reference model.
module tb_reg_writeback_unit;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 2;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          WB_VALID;
    logic [AW-1:0] WB_ADDR;
    logic [DW-1:0] WB_DATA;
    logic          MD_VALID;
    logic [AW-1:0] MD_ADDR;
    logic [DW-1:0] MD_DATA;
    logic          MD_READY;
    logic          ISSUE_MD;
    logic [AW-1:0] ISSUE_ADDR;
    logic [AW-1:0] RS1_ADDR;
    logic [AW-1:0] RS2_ADDR;
    logic [AW-1:0] RD_ADDR;
    logic          HAZARD;
    logic          RF_WRITE;
    logic [AW-1:0] RF_ADDR;
    logic [DW-1:0] RF_DATA;
`ifdef WB_FWD_EN
    logic          FWD1_HIT;
    logic [DW-1:0] FWD1_DATA;
    logic          FWD2_HIT;
    logic [DW-1:0] FWD2_DATA;
`endif

    always #5 CLK = ~CLK;

    reg_writeback_unit #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .MD_DEPTH (DEPTH)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .WB_VALID   (WB_VALID),
        .WB_ADDR    (WB_ADDR),
        .WB_DATA    (WB_DATA),
        .MD_VALID   (MD_VALID),
        .MD_ADDR    (MD_ADDR),
        .MD_DATA    (MD_DATA),
        .MD_READY   (MD_READY),
        .ISSUE_MD   (ISSUE_MD),
        .ISSUE_ADDR (ISSUE_ADDR),
        .RS1_ADDR   (RS1_ADDR),
        .RS2_ADDR   (RS2_ADDR),
        .RD_ADDR    (RD_ADDR),
        .HAZARD     (HAZARD),
        .RF_WRITE   (RF_WRITE),
        .RF_ADDR    (RF_ADDR),
        .RF_DATA    (RF_DATA)
`ifdef WB_FWD_EN
        ,
        .FWD1_HIT   (FWD1_HIT),
        .FWD1_DATA  (FWD1_DATA),
        .FWD2_HIT   (FWD2_HIT),
        .FWD2_DATA  (FWD2_DATA)
`endif
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    bit            pend [32];
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic step();
        bit   exp_ready;
        bit   exp_hz;
        bit   popping;
        bit   sel;
        ent_t s;
        ent_t head;
        #1;
        popping = !RESET && !WB_VALID && (q.size() > 0);
        if (q.size() > 0) head = q[0];
        exp_ready = !RESET && (q.size() < DEPTH);
        exp_hz = 1'b0;
        foreach (pend[i]) begin
            bit masked;
            masked = pend[i];
`ifdef WB_FWD_EN
            if (popping && head.a == AW'(i)) masked = 1'b0;
`endif
            if (masked && (RS1_ADDR == AW'(i) || RS2_ADDR == AW'(i) || RD_ADDR == AW'(i)))
                exp_hz = 1'b1;
        end
        check("md_ready", {63'd0, MD_READY}, {63'd0, exp_ready});
        check("hazard", {63'd0, HAZARD}, {63'd0, exp_hz});
`ifdef WB_FWD_EN
        begin
            bit h1, h2;
            h1 = m_we && m_addr == RS1_ADDR && RS1_ADDR != 0;
            h2 = m_we && m_addr == RS2_ADDR && RS2_ADDR != 0;
            check("fwd1_hit", {63'd0, FWD1_HIT}, {63'd0, h1});
            check("fwd2_hit", {63'd0, FWD2_HIT}, {63'd0, h2});
            if (h1) check("fwd1_data", {32'd0, FWD1_DATA}, {32'd0, m_data});
            if (h2) check("fwd2_data", {32'd0, FWD2_DATA}, {32'd0, m_data});
        end
`endif
        if (RESET) begin
            model_reset();
        end else begin
            bit push;
            push = MD_VALID && exp_ready;
            sel  = 1'b0;
            if (WB_VALID) begin
                sel = 1'b1;
                s.a = WB_ADDR;
                s.d = WB_DATA;
            end else if (q.size() > 0) begin
                sel = 1'b1;
                s   = q.pop_front();
                pend[s.a] = 1'b0;
            end
            if (push) q.push_back('{a: MD_ADDR, d: MD_DATA});
            if (ISSUE_MD && ISSUE_ADDR != 0) pend[ISSUE_ADDR] = 1'b1;
            m_we = sel && s.a != 0;
            if (m_we) begin
                m_addr = s.a;
                m_data = s.d;
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        check("rf_write", {63'd0, RF_WRITE}, {63'd0, m_we});
        check("rf_addr", {59'd0, RF_ADDR}, {59'd0, m_addr});
        check("rf_data", {32'd0, RF_DATA}, {32'd0, m_data});
    endtask

    task automatic idle();
        WB_VALID = 1'b0; WB_ADDR = '0; WB_DATA = '0;
        MD_VALID = 1'b0; MD_ADDR = '0; MD_DATA = '0;
        ISSUE_MD = 1'b0; ISSUE_ADDR = '0;
        RS1_ADDR = '0; RS2_ADDR = '0; RD_ADDR = '0;
    endtask

    initial begin
        idle();
        RESET    = 1'b1;
        MD_VALID = 1'b1;
        model_reset();
        @(negedge CLK);

        // Reset held for two cycles with a mul/div result offered.
        step();
        step();
        RESET    = 1'b0;
        MD_VALID = 1'b0;
        #1 check("t1_ready_after_reset", {63'd0, MD_READY}, 64'd1);
        step();

        // Single pipeline write.
        WB_VALID = 1'b1; WB_ADDR = 5'd5; WB_DATA = 32'hDEADBEEF;
        step();
        check("t2_write", {63'd0, RF_WRITE}, 64'd1);
        check("t2_data", {32'd0, RF_DATA}, 64'hDEADBEEF);
        idle();
        step();
        check("t2_one_cycle", {63'd0, RF_WRITE}, 64'd0);

        // Scoreboard stall until the mul/div result drains.
        ISSUE_MD = 1'b1; ISSUE_ADDR = 5'd7;
        step();
        ISSUE_MD = 1'b0; RS1_ADDR = 5'd7;
        #1 check("t3_hazard_set", {63'd0, HAZARD}, 64'd1);
        step();
        MD_VALID = 1'b1; MD_ADDR = 5'd7; MD_DATA = 32'h12345678;
        step();
        MD_VALID = 1'b0;
        step();
        check("t3_md_write", {32'd0, RF_DATA}, 64'h12345678);
        #1 check("t3_hazard_clear", {63'd0, HAZARD}, 64'd0);
        step();

        // FIFO fills behind a continuously busy pipeline.
        WB_VALID = 1'b1; WB_ADDR = 5'd3; WB_DATA = 32'hA5A5_0003;
        MD_VALID = 1'b1; MD_ADDR = 5'd10; MD_DATA = 32'h0000_0010;
        step();
        MD_ADDR = 5'd11; MD_DATA = 32'h0000_0011;
        step();
        #1 check("t4_full", {63'd0, MD_READY}, 64'd0);
        step();
        idle();
        step();
        check("t4_first", {59'd0, RF_ADDR}, 64'd10);
        #1 check("t4_ready_back", {63'd0, MD_READY}, 64'd1);
        step();
        check("t4_second", {59'd0, RF_ADDR}, 64'd11);

        // x0 handling for both sources and for issue.
        WB_VALID = 1'b1; WB_ADDR = 5'd0; WB_DATA = 32'hFFFF_FFFF;
        MD_VALID = 1'b1; MD_ADDR = 5'd0; MD_DATA = 32'h0BAD_0BAD;
        ISSUE_MD = 1'b1; ISSUE_ADDR = 5'd0;
        step();
        idle();
        step();
        check("t5_x0_pop_nowrite", {63'd0, RF_WRITE}, 64'd0);
        step();

`ifdef WB_FWD_EN
        WB_VALID = 1'b1; WB_ADDR = 5'd9; WB_DATA = 32'h9999_0009;
        step();
        idle();
        RS2_ADDR = 5'd9;
        #1 check("t6_fwd_hit", {63'd0, FWD2_HIT}, 64'd1);
        RS2_ADDR = 5'd0;
        #1 check("t6_fwd_x0", {63'd0, FWD2_HIT}, 64'd0);
        step();
`endif

        // Random traffic with a mid-run reset.
        for (int n = 0; n < 400; n++) begin
            RESET      = (n == 200 || n == 201);
            WB_VALID   = ($urandom_range(0, 99) < 45);
            WB_ADDR    = AW'($urandom_range(0, 9));
            WB_DATA    = $urandom;
            MD_VALID   = ($urandom_range(0, 99) < 50);
            MD_ADDR    = AW'($urandom_range(0, 9));
            MD_DATA    = $urandom;
            ISSUE_MD   = ($urandom_range(0, 99) < 30);
            ISSUE_ADDR = AW'($urandom_range(0, 9));
            RS1_ADDR   = AW'($urandom_range(0, 9));
            RS2_ADDR   = AW'($urandom_range(0, 9));
            RD_ADDR    = AW'($urandom_range(0, 9));
            step();
        end
        RESET = 1'b0;
        idle();
        for (int n = 0; n < 4; n++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_writeback_unit.md
Name: reg_writeback_unit

Overview:
Write-back stage that sits directly upstream of the register file's single write port (IN/INADDRESS/WRITE).
- Merges two result sources into one registered write per cycle:
  - the in-order pipeline MEM/WB result;
  - out-of-order multi-cycle M-extension (mul/div) results, buffered in a small FIFO.
- Keeps a pending-destination scoreboard so decode can stall on RAW/WAW hazards against in-flight mul/div results.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width (32 registers)
MD_DEPTH, 2, mul/div result FIFO entries; power of two, >= 2

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
WB_VALID  in  1  pipeline result valid this cycle; never back-pressured
WB_ADDR  in  ADDR_W  pipeline destination register
WB_DATA  in  DATA_W  pipeline result
MD_VALID  in  1  mul/div result valid
MD_ADDR  in  ADDR_W  mul/div destination register
MD_DATA  in  DATA_W  mul/div result
MD_READY  out  1  FIFO can accept; transfer on MD_VALID && MD_READY
ISSUE_MD  in  1  decode issues a mul/div op this cycle
ISSUE_ADDR  in  ADDR_W  destination of the issued mul/div op
RS1_ADDR  in  ADDR_W  decode source 1
RS2_ADDR  in  ADDR_W  decode source 2
RD_ADDR  in  ADDR_W  decode destination (WAW check)
HAZARD  out  1  decode must stall
RF_WRITE  out  1  to register file WRITE
RF_ADDR  out  ADDR_W  to register file INADDRESS
RF_DATA  out  DATA_W  to register file IN

Behaviour:
- Reset: while RESET is high at a CLK edge:
  - RF_WRITE=0, RF_ADDR=0, RF_DATA=0.
  - FIFO emptied; scoreboard cleared to all zeros.
  - Mid-operation reset discards queued mul/div results.
  - MD_READY=0 while RESET is high.
- RF_* outputs are registered: a source selected in cycle N appears on RF_* in cycle N+1, with RF_WRITE high for exactly one cycle per write.
- Arbitration, evaluated each cycle:
  - WB_VALID=1: the pipeline result wins; the FIFO does not pop.
  - Otherwise, if the FIFO is non-empty, the head entry pops and is written.
  - Otherwise RF_WRITE=0; RF_ADDR and RF_DATA hold their values.
- x0 rule: any selected write with address 0 yields RF_WRITE=0. It still consumes its slot: a FIFO entry still pops. The register file does not hard-wire x0.
- FIFO:
  - Circular, with read/write pointers plus a count; wrap-around at MD_DEPTH.
  - MD_READY = (count < MD_DEPTH) && !RESET.
  - Push and pop in the same cycle while full is not allowed, because MD_READY is already low.
  - Push and pop in the same cycle while non-full leaves count unchanged.
  - Push into an empty FIFO is not visible for pop until the next cycle (no fall-through).
- Scoreboard (pending[2**ADDR_W-1:0]):
  - Set pending[ISSUE_ADDR] on ISSUE_MD when ISSUE_ADDR != 0.
  - Clear pending[addr] when a FIFO entry is popped.
  - Set and clear of the same address in the same cycle: set wins.
  - pending[0] is always 0.
- HAZARD is combinational: pending[RS1_ADDR] | pending[RS2_ADDR] | pending[RD_ADDR].
  - It stays high until the cycle after the corresponding pop.
  - It covers the register file's read delay, because the value is in the register file one cycle after RF_WRITE.
- WB and a FIFO entry targeting the same address in the same cycle: the WB write goes first and the FIFO entry writes a later cycle. WAW stall in decode makes this legal-but-unreachable; no merging is done.

Optional Feature:
Macro WB_FWD_EN.
- Defined: adds outputs FWD1_HIT, FWD1_DATA, FWD2_HIT, FWD2_DATA.
  - FWDn_HIT = RF_WRITE && RF_ADDR == RSn_ADDR && RSn_ADDR != 0; FWDn_DATA = RF_DATA.
  - Decode muxes FWDn_DATA over the register-file output when FWDn_HIT is high.
  - HAZARD then ignores pending bits whose clear is occurring in the current cycle.
- Undefined: these ports are absent and HAZARD is as specified above.

Decomposition:
- Shared package constants: DATA_W, ADDR_W, REG_COUNT=32, X0_ADDR=0.
- Typedef wb_entry_t: {addr, data}.
- One sub-module: wb_result_fifo (parameterised MD_DEPTH, push/pop/count/full/empty). Arbitration and scoreboard stay in the top.

Test Plan:
1. RESET high for 2 cycles with MD_VALID=1 -> MD_READY=0, RF_WRITE=0, HAZARD=0; FIFO empty after release.
2. WB_VALID=1, WB_ADDR=5, WB_DATA=0xDEADBEEF -> next cycle RF_WRITE=1, RF_ADDR=5, RF_DATA=0xDEADBEEF, for one cycle.
3. ISSUE_MD to x7, then RS1_ADDR=7:
   - HAZARD=1 from the cycle after issue.
   - MD result {7, 0x12345678} with WB idle -> pop, RF write next cycle, HAZARD=0 the cycle after the pop.
4. Two MD results pushed while WB_VALID=1 continuously:
   - MD_READY drops after 2 pushes.
   - Release WB -> entries written in order in consecutive cycles; MD_READY returns high after the first pop.
5. WB_ADDR=0 or MD_ADDR=0 -> RF_WRITE stays 0; the FIFO entry still pops; no scoreboard bit set for ISSUE_ADDR=0.
6. WB_FWD_EN: RF_WRITE to x9 with RS2_ADDR=9 -> FWD2_HIT=1, FWD2_DATA=RF_DATA; RS2_ADDR=0 -> FWD2_HIT=0.
